// File: rtl/xcr_int_entry_seq.sv
// Interrupt entry/return sequencer: stalls the core to a boundary, masks INTC enable over XCR,
// redirects fetch to the vector and back on IRET. Optional boundary timeout: XCR_SEQ_TIMEOUT_EN.
module xcr_int_entry_seq #(
  parameter int unsigned PC_W      = 24,
  parameter logic [2:0]  INTC_ADR  = 3'h0,
  parameter int unsigned EN_RD_BIT = 2,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            int_req,
  input  logic [PC_W-1:0] ivec_addr,
  input  logic [PC_W-1:0] core_pc,
  input  logic            core_boundary,
  input  logic            iret,
  output logic            hold,
  output logic            redirect,
  output logic [PC_W-1:0] redirect_pc,
  output logic [PC_W-1:0] epc,
  output logic            in_isr,
  output logic            cr_busy,
  output logic            cr_cs,
  output logic            cr_we,
  output logic [2:0]      cr_adr,
  output logic [7:0]      cr_wdata,
  input  logic [7:0]      cr_rdata,
  output logic            seq_err
);

  typedef enum logic [2:0] {
    StIdle,
    StWaitBnd,
    StRdIntc,
    StWrDis,
    StEnter,
    StIsr,
    StRetWr,
    StRet
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] vec_q;
  logic [7:0]      saved_intc_q;
  logic            bus_d;

`ifdef XCR_SEQ_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  logic [CntW-1:0] cnt_q;
  logic            timeout_hit;
`endif

  always_comb begin
    state_d = state_q;
`ifdef XCR_SEQ_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    unique case (state_q)
      StIdle:    if (int_req && !in_isr) state_d = StWaitBnd;
      StWaitBnd: begin
        // A dropped request wins over a boundary seen in the same cycle.
        if (!int_req) begin
          state_d = StIdle;
        end else if (core_boundary) begin
          state_d = StRdIntc;
        end
`ifdef XCR_SEQ_TIMEOUT_EN
        else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          state_d     = StIdle;
          timeout_hit = 1'b1;
        end
`endif
      end
      StRdIntc:  state_d = StWrDis;
      StWrDis:   state_d = StEnter;
      StEnter:   state_d = StIsr;
      StIsr:     if (iret) state_d = StRetWr;
      StRetWr:   state_d = StRet;
      StRet:     state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  assign bus_d = (state_d == StRdIntc) || (state_d == StWrDis) || (state_d == StRetWr);

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      hold         <= 1'b0;
      redirect     <= 1'b0;
      redirect_pc  <= '0;
      epc          <= '0;
      in_isr       <= 1'b0;
      cr_busy      <= 1'b0;
      cr_cs        <= 1'b0;
      cr_we        <= 1'b0;
      cr_adr       <= 3'h0;
      cr_wdata     <= 8'h00;
      vec_q        <= '0;
      saved_intc_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      hold     <= (state_d != StIdle) && (state_d != StIsr);
      redirect <= (state_d == StEnter) || (state_d == StRet);
      in_isr   <= (state_d == StIsr) || (state_d == StRetWr) || (state_d == StRet);
      cr_busy  <= bus_d;
      cr_cs    <= bus_d;
      cr_we    <= (state_d == StWrDis) || (state_d == StRetWr);
      if (bus_d) cr_adr <= INTC_ADR;

      if (state_q == StWaitBnd && state_d == StRdIntc) begin
        epc   <= core_pc;
        vec_q <= ivec_addr;
      end
      if (state_q == StRdIntc) saved_intc_q <= cr_rdata;

      // WR_DIS is entered on the same edge that captures the read data.
      if (state_d == StWrDis) cr_wdata <= {1'b0, 5'b0, cr_rdata[1:0]};
      if (state_d == StRetWr) cr_wdata <= {saved_intc_q[EN_RD_BIT], 5'b0, saved_intc_q[1:0]};
      if (state_d == StEnter) redirect_pc <= vec_q;
      if (state_d == StRet)   redirect_pc <= epc;
    end
  end

`ifdef XCR_SEQ_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      seq_err <= 1'b0;
    end else begin
      cnt_q <= (state_q == StWaitBnd) ? cnt_q + 1'b1 : '0;
      if (timeout_hit) seq_err <= 1'b1;
    end
  end
`else
  assign seq_err = 1'b0;
`endif

  logic unused_bits;
  assign unused_bits = ^{saved_intc_q, TIMEOUT};

endmodule

// File: tb/tb_xcr_int_entry_seq.sv
// Self-checking bench for xcr_int_entry_seq: directed scenarios, then randomized traffic
// checked every cycle against a script-driven reference model.
module tb_xcr_int_entry_seq;

  localparam int unsigned TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        int_req;
  logic [23:0] ivec_addr;
  logic [23:0] core_pc;
  logic        core_boundary;
  logic        iret;
  logic        hold;
  logic        redirect;
  logic [23:0] redirect_pc;
  logic [23:0] epc;
  logic        in_isr;
  logic        cr_busy;
  logic        cr_cs;
  logic        cr_we;
  logic [2:0]  cr_adr;
  logic [7:0]  cr_wdata;
  logic [7:0]  cr_rdata;
  logic        seq_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  xcr_int_entry_seq dut (
    .clk          (clk),
    .rst          (rst),
    .int_req      (int_req),
    .ivec_addr    (ivec_addr),
    .core_pc      (core_pc),
    .core_boundary(core_boundary),
    .iret         (iret),
    .hold         (hold),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .epc          (epc),
    .in_isr       (in_isr),
    .cr_busy      (cr_busy),
    .cr_cs        (cr_cs),
    .cr_we        (cr_we),
    .cr_adr       (cr_adr),
    .cr_wdata     (cr_wdata),
    .cr_rdata     (cr_rdata),
    .seq_err      (seq_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: the activity of each cycle; fixed multi-cycle scripts are queued.
  typedef enum int {A_NONE, A_WAIT, A_READ, A_WDIS, A_ENTER, A_HANDLER, A_RETWR, A_RET} act_e;
  act_e        act = A_NONE;
  act_e        todo[$];
  logic [23:0] m_epc, m_vec, m_rpc;
  logic [7:0]  m_saved, m_wdata;
  logic        m_err;
  int          wcnt;

  task automatic model_step();
    act_e nxt;
    if (rst) begin
      act = A_NONE; todo.delete();
      m_epc = '0; m_vec = '0; m_rpc = '0; m_saved = '0; m_wdata = '0; m_err = 1'b0; wcnt = 0;
      return;
    end
    if (act == A_READ) m_saved = cr_rdata;
    nxt = act;
    if (todo.size() > 0) begin
      nxt = todo.pop_front();
    end else begin
      case (act)
        A_NONE: if (int_req) begin nxt = A_WAIT; wcnt = 0; end
        A_WAIT: begin
          if (!int_req) nxt = A_NONE;
          else if (core_boundary) begin
            m_epc = core_pc; m_vec = ivec_addr;
            nxt = A_READ; todo = '{A_WDIS, A_ENTER, A_HANDLER};
          end
`ifdef XCR_SEQ_TIMEOUT_EN
          else if (wcnt == TIMEOUT - 1) begin nxt = A_NONE; m_err = 1'b1; end
          else wcnt++;
`endif
        end
        A_HANDLER: if (iret) begin nxt = A_RETWR; todo = '{A_RET, A_NONE}; end
        default: ;
      endcase
    end
    case (nxt)
      A_WDIS:  m_wdata = {6'b0, m_saved[1:0]};
      A_RETWR: m_wdata = {m_saved[2], 5'b0, m_saved[1:0]};
      A_ENTER: m_rpc = m_vec;
      A_RET:   m_rpc = m_epc;
      default: ;
    endcase
    act = nxt;
  endtask

  task automatic compare_all();
    logic bus;
    bus = act inside {A_READ, A_WDIS, A_RETWR};
    check_eq("hold", hold, act inside {A_WAIT, A_READ, A_WDIS, A_ENTER, A_RETWR, A_RET});
    check_eq("redirect", redirect, act inside {A_ENTER, A_RET});
    check_eq("in_isr", in_isr, act inside {A_HANDLER, A_RETWR, A_RET});
    check_eq("cr_cs", cr_cs, bus);
    check_eq("cr_busy", cr_busy, bus);
    check_eq("cr_we", cr_we, act inside {A_WDIS, A_RETWR});
    check_eq("cr_adr", cr_adr, 3'h0);
    check_eq("cr_wdata", cr_wdata, m_wdata);
    check_eq("redirect_pc", redirect_pc, m_rpc);
    check_eq("epc", epc, m_epc);
    check_eq("seq_err", seq_err, m_err);
  endtask

  // Drive one cycle's inputs, advance the model, then check after the edge.
  task automatic cyc(input logic r, input logic ir, input logic bnd, input logic irt,
                     input logic [7:0] rd);
    rst = r; int_req = ir; core_boundary = bnd; iret = irt; cr_rdata = rd;
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    core_pc = 24'h000120; ivec_addr = 24'h001040;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    check_eq("reset_hold", hold, 1'b0);

    // Basic entry.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    check_eq("c1_hold", hold, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    check_eq("c2_read_cs", cr_cs, 1'b1);
    check_eq("c2_read_we", cr_we, 1'b0);
    core_pc = 24'h0BEEF0; ivec_addr = 24'h0DEAD0;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h07);
    check_eq("c3_wdata", cr_wdata, 8'h03);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    check_eq("c4_redirect", redirect, 1'b1);
    check_eq("c4_rpc", redirect_pc, 24'h001040);
    check_eq("c4_epc", epc, 24'h000120);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    check_eq("c5_in_isr", in_isr, 1'b1);
    // int_req held in the handler must not re-enter.
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    check_eq("isr_no_nest", hold, 1'b0);

    // Return.
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    check_eq("ret_wdata", cr_wdata, 8'h83);
    check_eq("ret_we", cr_we, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check_eq("ret_rpc", redirect_pc, 24'h000120);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check_eq("ret_in_isr", in_isr, 1'b0);

    // Stray iret in idle.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    check_eq("iret_idle_cs", cr_cs, 1'b0);

    // Abort before a boundary.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    check_eq("abort_hold", hold, 1'b0);
    check_eq("abort_epc", epc, 24'h000120);

    // Reset during WR_DIS.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'hFF);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    check_eq("rst_mid_cs", cr_cs, 1'b0);
    check_eq("rst_mid_epc", epc, 24'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

`ifdef XCR_SEQ_TIMEOUT_EN
    for (int i = 0; i < TIMEOUT + 2; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    check_eq("timeout_err", seq_err, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
`endif

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      logic r, ir, bnd, irt;
      core_pc   = 24'($urandom);
      ivec_addr = 24'($urandom);
      r   = ($urandom_range(0, 299) == 0);
      ir  = ($urandom_range(0, 5) == 0) ? ~int_req : int_req;
      bnd = ($urandom_range(0, 2) == 0);
      irt = ($urandom_range(0, 7) == 0);
      cyc(r, ir, bnd, irt, 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
